mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single MemoryMap port (MAB, MDBwrite, MDBread, MW, BW) between two masters: the CPU core and a DMA engine.
- Serialises accesses through a small FSM.
- Inserts configurable wait states for FRAM-region addresses.
- Uses DMA-priority arbitration with a starvation guard so a CPU request is never blocked for more than DMA_MAX_BURST consecutive DMA accesses.

Parameters:
FRAM_START, 16'h8000, first address of the FRAM region; addresses >= FRAM_START receive wait states
FRAM_WAIT, 1, extra ACCESS cycles inserted for FRAM-region accesses (0..7)
DMA_MAX_BURST, 4, maximum consecutive DMA grants while cpu_req is pending

Ports:
MCLK  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request; fields below held stable while high
cpu_MAB  in  16  CPU address
cpu_MDBwrite  in  16  CPU write data
cpu_MW  in  1  CPU write (1) / read (0)
cpu_BW  in  1  CPU byte access
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  16  read data for CPU, valid while cpu_ack=1
dma_req, dma_MAB, dma_MDBwrite, dma_MW, dma_BW  in  1/16/16/1/1  DMA equivalents
dma_ack  out  1  one-cycle completion pulse to DMA
dma_rdata  out  16  read data for DMA, valid while dma_ack=1
MAB  out  16  address to MemoryMap
MDBwrite  out  16  write data to MemoryMap
MW  out  1  memory write strobe to MemoryMap
BW  out  1  byte-write select to MemoryMap
MDBread  in  16  read data from MemoryMap (combinational from MAB)
owner  out  2  00 none, 01 CPU, 10 DMA; current access owner

Behaviour:
- Reset (rst=1 at the MCLK edge):
  - state goes to IDLE.
  - MAB, MDBwrite, MW, BW, cpu_ack, dma_ack, cpu_rdata, dma_rdata and owner are all cleared to 0.
  - The burst counter is cleared to 0.
  - Reset mid-access aborts the access: no ack is issued, and MW is 0 in the first cycle after reset.
- All outputs are registered.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If dma_req and (cpu_req=0 or burst_cnt<DMA_MAX_BURST): grant DMA.
  - Else if cpu_req: grant CPU.
  - Else: stay in IDLE.
  - On grant, latch the winner's address/data/MW/BW, set owner, and go to ACCESS.
  - Load wait_cnt = FRAM_WAIT if the latched address >= FRAM_START, else 0.
- Burst counter:
  - Increments on a DMA grant while cpu_req=1, saturating at DMA_MAX_BURST.
  - Clears on a CPU grant, or in any IDLE cycle with cpu_req=0.
- Address alignment: on a word access (BW=0), MAB[0] is forced to 0. On a byte access, MAB passes unchanged.
- ACCESS:
  - MAB, MDBwrite and BW are driven from the latched fields for the whole state.
  - While wait_cnt != 0: decrement wait_cnt and hold MW=0.
  - Final cycle (wait_cnt=0):
    - MW equals the latched write flag, so MW is high for exactly one cycle per write.
    - MDBread is captured into the owner's rdata register.
    - Go to DONE.
- DONE:
  - The owner's ack is 1 for this cycle only; MW=0; MAB holds its value.
  - Next state is IDLE, and owner is cleared.
  - Requesters must drop req, or present new fields, in the cycle after ack.
  - The non-owner's ack stays 0.
- Latency from a request sampled in IDLE to ack:
  - RAM: 2 cycles.
  - FRAM: 2+FRAM_WAIT cycles.
- Minimum back-to-back access period is 3+wait cycles (the IDLE cycle is mandatory).
- Requests arriving during ACCESS or DONE are not lost: they are evaluated in the next IDLE cycle.
- A req deasserted before grant is simply not serviced.
- The boundary address FRAM_START-2 is zero-wait; FRAM_START and 16'hFFFE (IVT) are FRAM-wait.

Test Plan:
1. CPU read of 0x2000 (RAM preloaded 0x5678), DMA idle -> MAB=0x2000 in cycle+1, MW=0 throughout; cpu_ack=1 in cycle+2 with cpu_rdata=0x5678; owner=01 in cycle+1.
2. CPU write to 0x8000 with data 0x1234, FRAM_WAIT=1 -> two ACCESS cycles with MW=0 then MW=1; cpu_ack in cycle+3; FRAM[0x8000] reads back 0x1234. Repeat at 0x7FFE -> ack in cycle+2.
3. cpu_req and dma_req asserted in the same cycle -> DMA served first (owner=10, dma_ack); CPU is granted in the IDLE after DMA's DONE.
4. dma_req held high continuously with cpu_req pending, DMA_MAX_BURST=4 -> exactly 4 dma_ack pulses, then a cpu_ack, then the DMA resumes.
5. CPU byte write to 0x23FE with data 0x00A5, BW=1 -> MW=1 and BW=1 for exactly one cycle; word at 0x23FE low byte becomes 0xA5, high byte unchanged. Word read of 0x2001 -> MAB driven as 0x2000.
6. rst pulsed during the FRAM wait cycle of a write to 0x8000 -> next cycle MW=0, owner=00, no ack; FRAM[0x8000] unchanged; the next request is serviced normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one MemoryMap port between the CPU and a DMA engine.
// A three-state FSM (IDLE -> ACCESS -> DONE) runs one access at a time.
// FRAM-region addresses get FRAM_WAIT extra ACCESS cycles.
// DMA has priority, but a pending CPU request is granted after at most
// DMA_MAX_BURST consecutive DMA grants.
// Ports:
//   MCLK, rst                               clock, synchronous active-high reset
//   cpu_req/MAB/MDBwrite/MW/BW              CPU request and access fields
//   cpu_ack, cpu_rdata                      CPU completion pulse and read data
//   dma_req/MAB/MDBwrite/MW/BW              DMA request and access fields
//   dma_ack, dma_rdata                      DMA completion pulse and read data
//   MAB, MDBwrite, MW, BW                   registered MemoryMap drive
//   MDBread                                 MemoryMap read data (combinational)
//   owner                                   00 none, 01 CPU, 10 DMA
module mem_bus_arbiter #(
    parameter logic [15:0] FRAM_START    = 16'h8000,
    parameter int unsigned FRAM_WAIT     = 1,
    parameter int unsigned DMA_MAX_BURST = 4
) (
    input  logic        MCLK,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [15:0] cpu_MAB,
    input  logic [15:0] cpu_MDBwrite,
    input  logic        cpu_MW,
    input  logic        cpu_BW,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    input  logic        dma_req,
    input  logic [15:0] dma_MAB,
    input  logic [15:0] dma_MDBwrite,
    input  logic        dma_MW,
    input  logic        dma_BW,
    output logic        dma_ack,
    output logic [15:0] dma_rdata,
    output logic [15:0] MAB,
    output logic [15:0] MDBwrite,
    output logic        MW,
    output logic        BW,
    input  logic [15:0] MDBread,
    output logic [1:0]  owner
);

    localparam int unsigned WAIT_W  = 3;
    localparam int unsigned BURST_B = $clog2(DMA_MAX_BURST + 1);
    localparam int unsigned BURST_W = (BURST_B < 1) ? 1 : BURST_B;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DMA  = 2'b10;

    logic [1:0]         state, state_nx;
    logic [WAIT_W-1:0]  wait_cnt, wait_nx;
    logic [BURST_W-1:0] burst_cnt, burst_nx;
    logic               lat_mw, lat_mw_nx;
    logic [15:0]        mab_nx, mdbwrite_nx, cpu_rdata_nx, dma_rdata_nx;
    logic               mw_nx, bw_nx, cpu_ack_nx, dma_ack_nx;
    logic [1:0]         owner_nx;

    logic               grant_dma, grant_cpu, sel_mw, sel_bw;
    logic [15:0]        sel_addr, sel_wdata;
    logic [WAIT_W-1:0]  sel_wait;

    // Arbitration and winner field selection.
    always_comb begin
        grant_dma = dma_req && (!cpu_req || (burst_cnt < BURST_W'(DMA_MAX_BURST)));
        grant_cpu = !grant_dma && cpu_req;
        sel_addr  = grant_dma ? dma_MAB      : cpu_MAB;
        sel_wdata = grant_dma ? dma_MDBwrite : cpu_MDBwrite;
        sel_mw    = grant_dma ? dma_MW       : cpu_MW;
        sel_bw    = grant_dma ? dma_BW       : cpu_BW;
        sel_wait  = (sel_addr >= FRAM_START) ? WAIT_W'(FRAM_WAIT) : '0;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx     = state;
        wait_nx      = wait_cnt;
        burst_nx     = burst_cnt;
        lat_mw_nx    = lat_mw;
        mab_nx       = MAB;
        mdbwrite_nx  = MDBwrite;
        bw_nx        = BW;
        mw_nx        = 1'b0;
        cpu_ack_nx   = 1'b0;
        dma_ack_nx   = 1'b0;
        cpu_rdata_nx = cpu_rdata;
        dma_rdata_nx = dma_rdata;
        owner_nx     = owner;

        case (state)
            IDLE: begin
                if (!cpu_req) begin
                    burst_nx = '0;
                end
                if (grant_dma || grant_cpu) begin
                    if (grant_dma) begin
                        owner_nx = OWN_DMA;
                        // grant_dma with cpu_req implies burst_cnt is below the limit
                        if (cpu_req) begin
                            burst_nx = burst_cnt + BURST_W'(1);
                        end
                    end else begin
                        owner_nx = OWN_CPU;
                        burst_nx = '0;
                    end
                    state_nx    = ACCESS;
                    mab_nx      = sel_bw ? sel_addr : {sel_addr[15:1], 1'b0};
                    mdbwrite_nx = sel_wdata;
                    bw_nx       = sel_bw;
                    lat_mw_nx   = sel_mw;
                    wait_nx     = sel_wait;
                    // MW is registered, so it is raised on entry to the final ACCESS cycle
                    mw_nx       = (sel_wait == '0) ? sel_mw : 1'b0;
                end
            end
            ACCESS: begin
                if (wait_cnt != '0) begin
                    wait_nx = wait_cnt - WAIT_W'(1);
                    mw_nx   = (wait_cnt == WAIT_W'(1)) ? lat_mw : 1'b0;
                end else begin
                    state_nx = DONE;
                    if (owner == OWN_DMA) begin
                        dma_rdata_nx = MDBread;
                        dma_ack_nx   = 1'b1;
                    end else begin
                        cpu_rdata_nx = MDBread;
                        cpu_ack_nx   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                owner_nx = OWN_NONE;
            end
            default: begin
                state_nx = IDLE;
                owner_nx = OWN_NONE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge MCLK) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            burst_cnt <= '0;
            lat_mw    <= 1'b0;
            MAB       <= '0;
            MDBwrite  <= '0;
            MW        <= 1'b0;
            BW        <= 1'b0;
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
            owner     <= OWN_NONE;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_nx;
            burst_cnt <= burst_nx;
            lat_mw    <= lat_mw_nx;
            MAB       <= mab_nx;
            MDBwrite  <= mdbwrite_nx;
            MW        <= mw_nx;
            BW        <= bw_nx;
            cpu_ack   <= cpu_ack_nx;
            dma_ack   <= dma_ack_nx;
            cpu_rdata <= cpu_rdata_nx;
            dma_rdata <= dma_rdata_nx;
            owner     <= owner_nx;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed steps with a per-master scoreboard
// of expected read data, popped on each ack; memory is a byte-array model.
module tb_mem_bus_arbiter;

    logic        MCLK = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_MW, cpu_BW, cpu_ack;
    logic [15:0] cpu_MAB, cpu_MDBwrite, cpu_rdata;
    logic        dma_req, dma_MW, dma_BW, dma_ack;
    logic [15:0] dma_MAB, dma_MDBwrite, dma_rdata;
    logic [15:0] MAB, MDBwrite, MDBread;
    logic        MW, BW;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit          chk;
        logic [15:0] d;
    } exp_t;

    exp_t cpu_q[$];
    exp_t dma_q[$];

    logic [7:0] mem [0:65535];

    always #5 MCLK = ~MCLK;

    mem_bus_arbiter #(
        .FRAM_START   (16'h8000),
        .FRAM_WAIT    (1),
        .DMA_MAX_BURST(4)
    ) dut (
        .MCLK        (MCLK),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_MAB     (cpu_MAB),
        .cpu_MDBwrite(cpu_MDBwrite),
        .cpu_MW      (cpu_MW),
        .cpu_BW      (cpu_BW),
        .cpu_ack     (cpu_ack),
        .cpu_rdata   (cpu_rdata),
        .dma_req     (dma_req),
        .dma_MAB     (dma_MAB),
        .dma_MDBwrite(dma_MDBwrite),
        .dma_MW      (dma_MW),
        .dma_BW      (dma_BW),
        .dma_ack     (dma_ack),
        .dma_rdata   (dma_rdata),
        .MAB         (MAB),
        .MDBwrite    (MDBwrite),
        .MW          (MW),
        .BW          (BW),
        .MDBread     (MDBread),
        .owner       (owner)
    );

    // MemoryMap model: combinational word read, write on MW at the clock edge.
    assign MDBread = {mem[{MAB[15:1], 1'b1}], mem[{MAB[15:1], 1'b0}]};

    always @(posedge MCLK) begin
        if (MW === 1'b1) begin
            if (BW === 1'b1) begin
                mem[MAB] <= MDBwrite[7:0];
            end else begin
                mem[{MAB[15:1], 1'b0}] <= MDBwrite[7:0];
                mem[{MAB[15:1], 1'b1}] <= MDBwrite[15:8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every ack must match an outstanding expectation for that master.
    always @(negedge MCLK) begin
        exp_t e;
        if (cpu_ack === 1'b1 && dma_ack === 1'b1) begin
            chk("dual_ack", 32'd1, 32'd0);
        end
        if (cpu_ack === 1'b1) begin
            chk("cpu_ack_expected", 32'(cpu_q.size() > 0), 32'd1);
            if (cpu_q.size() > 0) begin
                e = cpu_q.pop_front();
                if (e.chk) chk("cpu_rdata", 32'(cpu_rdata), 32'(e.d));
            end
        end
        if (dma_ack === 1'b1) begin
            chk("dma_ack_expected", 32'(dma_q.size() > 0), 32'd1);
            if (dma_q.size() > 0) begin
                e = dma_q.pop_front();
                if (e.chk) chk("dma_rdata", 32'(dma_rdata), 32'(e.d));
            end
        end
    end

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    task automatic setw(input logic [15:0] a, input logic [15:0] v);
        mem[{a[15:1], 1'b0}] = v[7:0];
        mem[{a[15:1], 1'b1}] = v[15:8];
    endtask

    function automatic logic [15:0] getw(input logic [15:0] a);
        return {mem[{a[15:1], 1'b1}], mem[{a[15:1], 1'b0}]};
    endfunction

    // One complete access by one master, ending in the following IDLE cycle.
    task automatic acc(input bit is_dma, input logic [15:0] a, input logic [15:0] d,
                       input bit w, input bit b, input int exp_lat,
                       input bit rchk, input logic [15:0] rexp);
        int          n, mwn;
        bit          got, bw_at_mw;
        logic [1:0]  own1;
        logic [15:0] mab1, exp_mab;
        exp_mab = b ? a : {a[15:1], 1'b0};
        if (is_dma) begin
            dma_MAB = a; dma_MDBwrite = d; dma_MW = w; dma_BW = b; dma_req = 1'b1;
            dma_q.push_back('{rchk, rexp});
        end else begin
            cpu_MAB = a; cpu_MDBwrite = d; cpu_MW = w; cpu_BW = b; cpu_req = 1'b1;
            cpu_q.push_back('{rchk, rexp});
        end
        n = 0; mwn = 0; got = 0; bw_at_mw = 0; own1 = 2'b00; mab1 = 16'h0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (n == 1) begin own1 = owner; mab1 = MAB; end
            if (MW === 1'b1) begin mwn++; bw_at_mw = BW; end
            if ((is_dma ? dma_ack : cpu_ack) === 1'b1) got = 1;
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        chk("ack_seen", 32'(got), 32'd1);
        chk("latency", 32'(n), 32'(exp_lat));
        chk("owner_c1", 32'(own1), is_dma ? 32'd2 : 32'd1);
        chk("mab_c1", 32'(mab1), 32'(exp_mab));
        chk("mw_cycles", 32'(mwn), 32'(w));
        if (w) chk("bw_at_mw", 32'(bw_at_mw), 32'(b));
        tick();
    endtask

    initial begin
        int nd, cpu_at, dma_at, dma5_at, cpu_pos, acks;
        logic [1:0] own1;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        setw(16'h2000, 16'h5678);
        setw(16'h23FE, 16'hBEEF);
        setw(16'h4000, 16'hD00D);
        setw(16'h7FFE, 16'h1111);
        setw(16'h8000, 16'hCAFE);
        setw(16'hFFFE, 16'hF00D);

        rst = 1'b1;
        cpu_req = 0; cpu_MAB = 0; cpu_MDBwrite = 0; cpu_MW = 0; cpu_BW = 0;
        dma_req = 0; dma_MAB = 0; dma_MDBwrite = 0; dma_MW = 0; dma_BW = 0;
        tick();
        tick();
        chk("rst_MAB", 32'(MAB), 32'd0);
        chk("rst_MDBwrite", 32'(MDBwrite), 32'd0);
        chk("rst_MW", 32'(MW), 32'd0);
        chk("rst_BW", 32'(BW), 32'd0);
        chk("rst_acks", 32'({cpu_ack, dma_ack}), 32'd0);
        chk("rst_rdata", 32'({cpu_rdata, dma_rdata}), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        rst = 1'b0;
        tick();

        // CPU RAM read, DMA idle
        acc(0, 16'h2000, 16'h0000, 0, 0, 2, 1, 16'h5678);

        // FRAM write with wait state, then boundary RAM write
        acc(0, 16'h8000, 16'h1234, 1, 0, 3, 0, 16'h0000);
        chk("fram_8000", 32'(getw(16'h8000)), 32'h1234);
        acc(0, 16'h7FFE, 16'h4321, 1, 0, 2, 0, 16'h0000);
        chk("ram_7FFE", 32'(getw(16'h7FFE)), 32'h4321);
        acc(0, 16'h8000, 16'h0000, 0, 0, 3, 1, 16'h1234);
        acc(1, 16'hFFFE, 16'h0000, 0, 0, 3, 1, 16'hF00D);

        // Simultaneous requests: DMA first, CPU in the IDLE after DMA's DONE
        cpu_MAB = 16'h2000; cpu_MW = 0; cpu_BW = 0;
        dma_MAB = 16'h4000; dma_MW = 0; dma_BW = 0;
        cpu_q.push_back('{1'b1, 16'h5678});
        dma_q.push_back('{1'b1, 16'hD00D});
        cpu_req = 1; dma_req = 1;
        cpu_at = 0; dma_at = 0; own1 = 2'b00;
        for (int t = 1; t <= 20 && (cpu_at == 0 || dma_at == 0); t++) begin
            tick();
            if (t == 1) own1 = owner;
            if (dma_ack === 1'b1) begin dma_at = t; dma_req = 0; end
            if (cpu_ack === 1'b1) begin cpu_at = t; cpu_req = 0; end
        end
        cpu_req = 0; dma_req = 0;
        chk("both_owner_c1", 32'(own1), 32'd2);
        chk("both_dma_at", 32'(dma_at), 32'd2);
        chk("both_cpu_at", 32'(cpu_at), 32'd5);
        tick();

        // Continuous DMA with CPU pending: four DMA grants, then CPU, then DMA
        cpu_q.push_back('{1'b1, 16'h5678});
        for (int i = 0; i < 5; i++) dma_q.push_back('{1'b1, 16'hD00D});
        cpu_req = 1; dma_req = 1;
        nd = 0; cpu_at = 0; dma5_at = 0; cpu_pos = -1;
        for (int t = 1; t <= 40 && nd < 5; t++) begin
            tick();
            if (dma_ack === 1'b1) begin
                nd++;
                if (nd == 5) begin dma5_at = t; dma_req = 0; end
            end
            if (cpu_ack === 1'b1) begin cpu_pos = nd; cpu_at = t; cpu_req = 0; end
        end
        cpu_req = 0; dma_req = 0;
        chk("burst_dma_before_cpu", 32'(cpu_pos), 32'd4);
        chk("burst_cpu_at", 32'(cpu_at), 32'd14);
        chk("burst_dma5_at", 32'(dma5_at), 32'd17);
        tick();

        // Byte write, then unaligned word read
        acc(0, 16'h23FE, 16'h00A5, 1, 1, 2, 0, 16'h0000);
        chk("byte_write", 32'(getw(16'h23FE)), 32'hBEA5);
        acc(0, 16'h23FE, 16'h0000, 0, 0, 2, 1, 16'hBEA5);
        acc(0, 16'h2001, 16'h0000, 0, 0, 2, 1, 16'h5678);

        // Reset during the FRAM wait cycle of a write
        cpu_MAB = 16'h8000; cpu_MDBwrite = 16'h9999; cpu_MW = 1; cpu_BW = 0; cpu_req = 1;
        tick();
        chk("abort_wait_mw", 32'(MW), 32'd0);
        chk("abort_wait_owner", 32'(owner), 32'd1);
        rst = 1;
        tick();
        rst = 0; cpu_req = 0; cpu_MW = 0;
        chk("abort_mw", 32'(MW), 32'd0);
        chk("abort_owner", 32'(owner), 32'd0);
        acks = 0;
        for (int t = 0; t < 4; t++) begin
            if (cpu_ack === 1'b1 || dma_ack === 1'b1) acks++;
            tick();
        end
        chk("abort_no_ack", 32'(acks), 32'd0);
        chk("abort_fram", 32'(getw(16'h8000)), 32'h1234);
        acc(0, 16'h8000, 16'h0000, 0, 0, 3, 1, 16'h1234);

        chk("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
        chk("dma_q_empty", 32'(dma_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
